// File: rtl/harris_nms_pkg.sv
// Shared types and defaults for the Harris corner pipeline.
// The downstream corner collector consumes corner_t records.
package harris_pkg;

    localparam int RW_DEF     = 32;
    localparam int WIDTH_DEF  = 320;
    localparam int HEIGHT_DEF = 240;
    localparam int XW_DEF     = $clog2(WIDTH_DEF);
    localparam int YW_DEF     = $clog2(HEIGHT_DEF);

    typedef struct packed {
        logic [XW_DEF-1:0]        x;
        logic [YW_DEF-1:0]        y;
        logic signed [RW_DEF-1:0] score;
    } corner_t;

endpackage

// File: rtl/harris_nms_line_buffer.sv
// One-line delay RAM with read-before-write: rdata_o is the contents of addr_i
// before this beat's write lands, and the consumer registers it into its window.
module harris_line_buffer
    import harris_pkg::*;
#(
    parameter int DEPTH = WIDTH_DEF,
    parameter int DW    = RW_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Never cleared: stale rows only ever feed border centers.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/harris_nms.sv
// Threshold plus 3x3 non-maximum suppression on a raster Harris response stream.
// Fixed 2-cycle latency, no backpressure; ties resolve to the raster-first pixel.
module harris_nms
    import harris_pkg::*;
#(
    parameter int                 WIDTH  = WIDTH_DEF,
    parameter int                 HEIGHT = HEIGHT_DEF,
    parameter int                 RW     = RW_DEF,
    parameter logic signed [RW-1:0] THRESH = 32'sd100000,
    parameter int                 XW     = $clog2(WIDTH),
    parameter int                 YW     = $clog2(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [RW-1:0] resp,
    input  logic                 resp_valid,
    output logic                 corner_valid,
    output logic [XW-1:0]        corner_x,
    output logic [YW-1:0]        corner_y,
    output logic signed [RW-1:0] corner_score,
    output logic                 frame_done
);

    logic [XW-1:0]        in_x_q, in_x_d;
    logic [YW-1:0]        in_y_q, in_y_d;
    logic                 x_last, y_last;
    logic signed [RW-1:0] lb1_rd, lb2_rd;
    logic signed [RW-1:0] win_q [3][3];
    logic [XW-1:0]        cx_q;
    logic [YW-1:0]        cy_q;
    logic                 elig_q, last_q;
    logic                 corner_valid_q, frame_done_q;
    logic [XW-1:0]        corner_x_q;
    logic [YW-1:0]        corner_y_q;
    logic signed [RW-1:0] corner_score_q;
    logic signed [RW-1:0] center;
    logic                 beats_earlier, holds_later, is_corner;

    assign x_last = (in_x_q == XW'(WIDTH - 1));
    assign y_last = (in_y_q == YW'(HEIGHT - 1));

    always_comb begin
        in_x_d = in_x_q;
        in_y_d = in_y_q;
        if (resp_valid) begin
            if (x_last) begin
                in_x_d = '0;
                in_y_d = y_last ? '0 : in_y_q + YW'(1);
            end else begin
                in_x_d = in_x_q + XW'(1);
            end
        end
    end

    harris_line_buffer #(.DEPTH(WIDTH), .DW(RW)) u_lb1 (
        .clk     (clk),
        .en_i    (resp_valid),
        .addr_i  (in_x_q),
        .wdata_i (resp),
        .rdata_o (lb1_rd)
    );

    harris_line_buffer #(.DEPTH(WIDTH), .DW(RW)) u_lb2 (
        .clk     (clk),
        .en_i    (resp_valid),
        .addr_i  (in_x_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    // Window rows: 0 = y-2, 1 = y-1, 2 = y; columns: 0 = x-2, 1 = x-1, 2 = x.
    assign center        = win_q[1][1];
    assign beats_earlier = (center > win_q[0][0]) && (center > win_q[0][1]) &&
                           (center > win_q[0][2]) && (center > win_q[1][0]);
    assign holds_later   = (center >= win_q[1][2]) && (center >= win_q[2][0]) &&
                           (center >= win_q[2][1]) && (center >= win_q[2][2]);
    assign is_corner     = (center > THRESH) && beats_earlier && holds_later;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_x_q         <= '0;
            in_y_q         <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            cx_q           <= '0;
            cy_q           <= '0;
            elig_q         <= 1'b0;
            last_q         <= 1'b0;
            corner_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            corner_x_q     <= '0;
            corner_y_q     <= '0;
            corner_score_q <= '0;
        end else begin
            in_x_q <= in_x_d;
            in_y_q <= in_y_d;
            if (resp_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= resp;
                cx_q        <= in_x_q - XW'(1);
                cy_q        <= in_y_q - YW'(1);
            end
            // Center (x-1, y-1) is interior iff x >= 2 and y >= 2.
            elig_q         <= resp_valid && (in_x_q >= XW'(2)) && (in_y_q >= YW'(2));
            last_q         <= resp_valid && x_last && y_last;
            corner_valid_q <= elig_q && is_corner;
            frame_done_q   <= last_q;
            if (elig_q && is_corner) begin
                corner_x_q     <= cx_q;
                corner_y_q     <= cy_q;
                corner_score_q <= center;
            end
        end
    end

    assign corner_valid = corner_valid_q;
    assign corner_x     = corner_x_q;
    assign corner_y     = corner_y_q;
    assign corner_score = corner_score_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_harris_nms.sv
// Bench for harris_nms: two instances (THRESH 100 and -10) share one stream and are
// compared against a direct per-pixel corner model, plus table expectations.
module tb_harris_nms;

    localparam int W = 16;
    localparam int H = 8;

    typedef struct { int x; int y; int s; int t; } rec_t;
    typedef struct { int bg; int gap; int rnd; int na; int nb; int ex; int ey; int es; } vec_t;
    typedef struct { int f; int x; int y; int v; } peak_t;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] resp;
    logic               resp_valid;
    logic               cv_a, fd_a, cv_b, fd_b;
    logic [3:0]         cx_a, cx_b;
    logic [2:0]         cy_a, cy_b;
    logic signed [31:0] sc_a, sc_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   img[H][W];
    int   beat_cyc[H][W];
    rec_t obs_a[$], obs_b[$], exp_q[$];
    int   fds_a[$], fds_b[$];
    vec_t vecs[9];
    peak_t peaks[$];

    harris_nms #(.WIDTH(W), .HEIGHT(H), .RW(32), .THRESH(32'sd100)) dut_a (
        .clk(clk), .reset(reset), .resp(resp), .resp_valid(resp_valid),
        .corner_valid(cv_a), .corner_x(cx_a), .corner_y(cy_a),
        .corner_score(sc_a), .frame_done(fd_a));

    harris_nms #(.WIDTH(W), .HEIGHT(H), .RW(32), .THRESH(-32'sd10)) dut_b (
        .clk(clk), .reset(reset), .resp(resp), .resp_valid(resp_valid),
        .corner_valid(cv_b), .corner_x(cx_b), .corner_y(cy_b),
        .corner_score(sc_b), .frame_done(fd_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cv_a) obs_a.push_back('{int'(cx_a), int'(cy_a), int'(sc_a), cyc});
        if (cv_b) obs_b.push_back('{int'(cx_b), int'(cy_b), int'(sc_b), cyc});
        if (fd_a) fds_a.push_back(cyc);
        if (fd_b) fds_b.push_back(cyc);
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: every interior pixel tested against its 8 neighbours; output
    // appears two cycles after the beat that presents pixel (cx+1, cy+1).
    function automatic void model(input int th);
        exp_q.delete();
        for (int cy = 1; cy <= H - 2; cy++) begin
            for (int cx = 1; cx <= W - 2; cx++) begin
                int c = img[cy][cx];
                bit ok = (c > th);
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int n = img[cy+dy][cx+dx];
                        if (dy == 0 && dx == 0) continue;
                        if (dy < 0 || (dy == 0 && dx < 0)) ok = ok && (c > n);
                        else ok = ok && (c >= n);
                    end
                end
                if (ok) exp_q.push_back('{cx, cy, c, beat_cyc[cy+1][cx+1] + 2});
            end
        end
    endfunction

    task automatic check_dut(input string tag, input int th, input rec_t obs[$], input int fds[$],
                             input int exp_n, input int ex, input int ey, input int es);
        int n;
        model(th);
        chk({tag, " corner_count_model"}, obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " corner_x"}, obs[i].x, exp_q[i].x);
            chk({tag, " corner_y"}, obs[i].y, exp_q[i].y);
            chk({tag, " corner_score"}, obs[i].s, exp_q[i].s);
            chk({tag, " corner_cycle"}, obs[i].t, exp_q[i].t);
        end
        chk({tag, " frame_done_count"}, fds.size(), 1);
        if (fds.size() > 0) chk({tag, " frame_done_cycle"}, fds[0], beat_cyc[H-1][W-1] + 2);
        if (exp_n >= 0) chk({tag, " corner_count_table"}, obs.size(), exp_n);
        if (exp_n == 1 && obs.size() > 0) begin
            chk({tag, " table_x"}, obs[0].x, ex);
            chk({tag, " table_y"}, obs[0].y, ey);
            chk({tag, " table_score"}, obs[0].s, es);
        end
    endtask

    task automatic idle();
        resp_valid = 1'b0;
        resp = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic beat(input int x, input int y);
        resp_valid = 1'b1;
        resp = img[y][x];
        beat_cyc[y][x] = cyc;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int gap);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                for (int g = 0; g < 5 && $urandom_range(0, 99) < gap; g++) idle();
                beat(x, y);
            end
        end
        repeat (4) idle();
    endtask

    task automatic build_image(input int f);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = vecs[f].rnd ? int'($urandom_range(0, 8)) * 60 - 200 : vecs[f].bg;
        foreach (peaks[i]) if (peaks[i].f == f) img[peaks[i].y][peaks[i].x] = peaks[i].v;
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_b.delete(); fds_a.delete(); fds_b.delete();
    endtask

    initial begin
        //            bg   gap rnd  na  nb  ex ey  es
        vecs[0] = '{   0,  0, 0,  0,  0, 0, 0,    0};
        vecs[1] = '{   0,  0, 0,  1,  1, 5, 3, 1000};
        vecs[2] = '{   0,  0, 0,  0,  0, 0, 0,    0};
        vecs[3] = '{   0,  0, 0,  1,  1, 5, 3,  500};
        vecs[4] = '{   0,  0, 0,  0,  1, 5, 3,  100};
        vecs[5] = '{ -20,  0, 0,  0,  1, 5, 3,   -5};
        vecs[6] = '{   0, 40, 0,  1,  1, 5, 3, 1000};
        vecs[7] = '{   0,  0, 1, -1, -1, 0, 0,    0};
        vecs[8] = '{   0, 30, 1, -1, -1, 0, 0,    0};
        peaks = '{'{1, 5, 3, 1000}, '{2, 0, 3, 1000}, '{2, 15, 7, 1000}, '{2, 7, 0, 1000},
                  '{3, 5, 3, 500}, '{3, 6, 3, 500}, '{4, 5, 3, 100}, '{5, 5, 3, -5},
                  '{6, 5, 3, 1000}};

        reset = 1'b1;
        resp_valid = 1'b0;
        resp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset corner_valid", cv_a, 0);
        chk("reset frame_done", fd_a, 0);
        chk("reset corner_x", cx_a, 0);
        chk("reset corner_y", cy_a, 0);
        chk("reset corner_score", sc_a, 0);
        reset = 1'b0;
        clear_obs();

        // Frames run back to back; each leaves its rows in the line buffers.
        for (int f = 0; f < 9; f++) begin
            build_image(f);
            run_frame(vecs[f].gap);
            check_dut($sformatf("f%0d thr100", f), 100, obs_a, fds_a, vecs[f].na,
                      vecs[f].ex, vecs[f].ey, vecs[f].es);
            check_dut($sformatf("f%0d thr-10", f), -10, obs_b, fds_b, vecs[f].nb,
                      vecs[f].ex, vecs[f].ey, vecs[f].es);
            clear_obs();
        end

        // Partial frame with a corner at (5,1), then reset mid-row 2.
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
        img[1][5] = 1000;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < W && !(y == 2 && x > 9); x++) beat(x, y);
        repeat (3) idle();
        chk("midframe corner_x before reset", cx_a, 5);
        chk("midframe corner_y before reset", cy_a, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset corner_x", cx_a, 0);
        chk("midreset corner_score", sc_a, 0);
        chk("midreset corner_valid", cv_a, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_obs();
        build_image(1);
        run_frame(0);
        check_dut("post-reset thr100", 100, obs_a, fds_a, 1, 5, 3, 1000);
        check_dut("post-reset thr-10", -10, obs_b, fds_b, 1, 5, 3, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
